// File: rtl/alu_arbiter.sv
// +------------------------------------------------------------------------+
// | Module   : alu_arbiter                                                  |
// | Brief    : Round-robin arbiter sharing one ALU between NUM_REQ clients,  |
// |            with start/done handshake, timeout and response channel.     |
// | Revision : 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
`default_nettype none

module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic [3*NUM_REQ-1:0]       i_req_op,
  input  logic [DATA_W*NUM_REQ-1:0]  i_req_a,
  input  logic [DATA_W*NUM_REQ-1:0]  i_req_b,
  output logic [2:0]                 o_alu_op,
  output logic [DATA_W-1:0]          o_alu_a,
  output logic [DATA_W-1:0]          o_alu_b,
  output logic                       o_alu_start,
  input  logic                       i_alu_done,
  input  logic [DATA_W-1:0]          i_alu_result,
  input  logic                       i_alu_flag,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] o_rsp_id,
  output logic [DATA_W-1:0]          o_rsp_result,
  output logic                       o_rsp_flag,
  output logic                       o_rsp_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [ID_W:0]      c_num_req  = (ID_W+1)'(NUM_REQ);
  localparam logic [CNT_W-1:0]   c_cnt_last = CNT_W'(TIMEOUT-1);
  localparam logic [2:0]         c_op_gt    = 3'd5;
  localparam logic [2:0]         c_op_eq    = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state, w_next;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_op;
  logic [DATA_W-1:0]   r_a, r_b, r_result;
  logic [ID_W-1:0]     r_id;
  logic                r_flag, r_err;

  logic [NUM_REQ-1:0]  w_rot;
  logic                w_any, w_accept, w_hs, w_tmo;
  logic [ID_W-1:0]     w_pos, w_win, w_next_ptr;
  logic [ID_W:0]       w_sum, w_id_inc;
  logic [2:0]          w_sel_op;
  logic [DATA_W-1:0]   w_sel_a, w_sel_b;

  // Rotate requests so bit 0 is the current priority holder, then pick the lowest set bit.
  always_comb begin
    w_rot = NUM_REQ'({i_req_valid, i_req_valid} >> r_rr_ptr);
    w_any = |w_rot;
    w_pos = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (w_rot[k]) w_pos = ID_W'(k);
    end
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_pos};
    w_win = ID_W'((w_sum >= c_num_req) ? (w_sum - c_num_req) : w_sum);
  end

  always_comb begin
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_win == ID_W'(k)) begin
        w_sel_op = i_req_op[3*k +: 3];
        w_sel_a  = i_req_a[DATA_W*k +: DATA_W];
        w_sel_b  = i_req_b[DATA_W*k +: DATA_W];
      end
    end
  end

  assign w_accept    = rst_n && (r_state == S_IDLE) && w_any;
  assign w_hs        = (r_state == S_RESP) && i_rsp_ready;
  assign w_tmo       = (r_state == S_WAIT) && !i_alu_done && (r_cnt == c_cnt_last);
  assign w_id_inc    = {1'b0, r_id} + (ID_W+1)'(1);
  assign w_next_ptr  = ID_W'((w_id_inc == c_num_req) ? '0 : w_id_inc);

  assign o_req_ready  = w_accept ? (NUM_REQ'(1) << w_win) : '0;
  assign o_alu_start  = (r_state == S_ISSUE);
  assign o_alu_op     = r_op;
  assign o_alu_a      = r_a;
  assign o_alu_b      = r_b;
  assign o_rsp_valid  = (r_state == S_RESP);
  assign o_rsp_id     = r_id;
  assign o_rsp_result = r_result;
  assign o_rsp_flag   = r_flag;
  assign o_rsp_err    = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (i_alu_done || w_tmo) w_next = S_RESP;
      S_RESP:  if (i_rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_id     <= '0;
      r_result <= '0;
      r_flag   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= w_sel_op;
        r_a  <= w_sel_a;
        r_b  <= w_sel_b;
        r_id <= w_win;
      end
      if (r_state == S_WAIT) begin
        if (i_alu_done) begin
          r_result <= i_alu_result;
          // Only compare ops produce a meaningful flag.
          r_flag   <= i_alu_flag && ((r_op == c_op_gt) || (r_op == c_op_eq));
          r_err    <= 1'b0;
        end else if (w_tmo) begin
          r_result <= '0;
          r_flag   <= 1'b0;
          r_err    <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      if (w_hs) begin
        r_rr_ptr <= w_next_ptr;
        r_cnt    <= '0;
      end
    end
  end

endmodule

`default_nettype wire
